// File: rtl/vector_pkg.sv
// Shared types and width helpers for the scalar-to-vector packer.
package vector_pkg;

    typedef enum logic [0:0] {
        FILL,
        FULL
    } state_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/vector_lane_counter.sv
// Lane index register: advances per accepted element and returns to lane 0 when a vector closes.
module vector_lane_counter
    import vector_pkg::*;
#(
    parameter int unsigned vector_length = 7
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                inc,
    input  logic                                clr,
    output logic [idx_width(vector_length)-1:0] idx,
    output logic                                at_last_lane
);

    localparam int unsigned IdxW = idx_width(vector_length);

    // Clear wins over increment so a closing element never walks idx past the last lane.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx <= '0;
        end else if (clr) begin
            idx <= '0;
        end else if (inc) begin
            idx <= idx + IdxW'(1);
        end
    end

    assign at_last_lane = (idx == IdxW'(vector_length - 1));

endmodule

// File: rtl/vector_pack.sv
// Packs a stream of scalar elements into vector_length-lane vectors; short vectors end on in_last
// and leave their unwritten lanes at zero.
module vector_pack
    import vector_pkg::*;
#(
    parameter int unsigned vector_length = 7,
    parameter int unsigned data_width    = 48
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [data_width-1:0]                 in_data,
    input  logic                                  in_valid,
    input  logic                                  in_last,
    output logic                                  in_ready,
    output logic [vector_length*data_width-1:0]   vector_out,
    output logic                                  vector_valid,
    input  logic                                  vector_ready,
    output logic [cnt_width(vector_length)-1:0]   vector_count
);

    localparam int unsigned IdxW = idx_width(vector_length);
    localparam int unsigned CntW = cnt_width(vector_length);

    state_e              state_q;
    logic [IdxW-1:0]     idx;
    logic                at_last_lane;
    logic                accept;
    logic                handoff;
    logic                close;
    logic [data_width-1:0] lane_q [vector_length];

    assign vector_valid = (state_q == FULL);
    assign in_ready     = !reset && (!vector_valid || vector_ready);
    assign accept       = in_valid && in_ready;
    assign handoff      = vector_valid && vector_ready;
    assign close        = accept && (in_last || at_last_lane);

    vector_lane_counter #(
        .vector_length (vector_length)
    ) u_lane_counter (
        .clk          (clk),
        .reset        (reset),
        .inc          (accept && !close),
        .clr          (close),
        .idx          (idx),
        .at_last_lane (at_last_lane)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= FILL;
            vector_count <= '0;
        end else if (close) begin
            state_q      <= FULL;
            vector_count <= CntW'(idx) + CntW'(1);
        end else if (handoff) begin
            state_q      <= FILL;
            vector_count <= '0;
        end
    end

    // idx is always 0 during a handoff, so a simultaneous accept lands in lane 0 of a cleared vector.
    for (genvar i = 0; i < vector_length; i++) begin : g_lane
        logic we;
        assign we = accept && (idx == IdxW'(i));

        always_ff @(posedge clk) begin
            if (reset) begin
                lane_q[i] <= '0;
            end else if (we) begin
                lane_q[i] <= in_data;
            end else if (handoff) begin
                lane_q[i] <= '0;
            end
        end
    end

    always_comb begin
        vector_out = '0;
        for (int i = 0; i < vector_length; i++) begin
            vector_out[i*data_width +: data_width] = lane_q[i];
        end
    end

endmodule
